uart_rx_oversample: RTL
=======================

// Module: uart_rx_oversample
// PURPOSE
//   8N1 UART receiver using 16x oversampling.
//   Takes the raw asynchronous serial line from the board pin.
//   Emits one byte per frame with a single-cycle rx_done strobe, which feeds the
//   ASCII command decoder directly (rx_data/rx_done).
//   Filters start-bit glitches and flags framing errors without emitting data.
// PARAMETERS
//   CLK_FREQ    100_000_000  system clock frequency, Hz
//   BAUD        9600         line rate, bit/s
//   OVERSAMPLE  16           sample ticks per bit; must be even, >= 8
//   (derived) DIV = CLK_FREQ/(BAUD*OVERSAMPLE), integer truncation (651 at defaults)
// PORTS
//   clk        in   1  system clock, rising edge
//   rst        in   1  synchronous reset, active-high
//   rx         in   1  raw serial line; idles high; asynchronous to clk
//   rx_data    out  8  last correctly framed byte, LSB received first
//   rx_done    out  1  one-cycle pulse; rx_data is valid from this cycle onward
//   rx_busy    out  1  high while a frame is in progress (state != IDLE)
//   frame_err  out  1  one-cycle pulse when the stop bit samples low
// BEHAVIOUR
//   Interface: one clock (clk); rst is synchronous and active-high.
//     All state changes happen only on posedge clk.
//   Reset values
//     rx_data=8'h00, rx_done=0, rx_busy=0, frame_err=0.
//     Synchroniser flops=1, tick counter=0, sample counter=0, bit counter=0, state=IDLE.
//     A reset asserted mid-frame aborts the frame; no rx_done is produced.
//   Input synchroniser
//     2-flop synchroniser on rx. All logic uses the 2nd stage (rx_s).
//     This adds 2 cycles of input latency.
//   Tick generator
//     Free-running counter 0..DIV-1. tick=1 for one cycle when the count equals DIV-1,
//     then the counter wraps to 0.
//     Runs in every state, so the start-edge phase error is < 1 tick.
//   FSM (sample counter s counts ticks 0..OVERSAMPLE-1; bit counter b runs 0..7)
//     IDLE  : rx_s==0 -> START, s=0. Otherwise stay.
//     START : on tick, s++. When s==OVERSAMPLE/2-1 (mid start bit):
//             rx_s==0 -> DATA with s=0, b=0; else -> IDLE (glitch, no outputs).
//     DATA  : on tick, s++. When s==OVERSAMPLE-1 (mid data bit):
//             shift rx_s into shreg MSB (right shift, LSB first); s=0.
//             If b==7 -> STOP; else b++.
//     STOP  : on tick, s++. When s==OVERSAMPLE-1:
//             rx_s==1 -> rx_data<=shreg, rx_done=1 (next cycle), -> IDLE.
//             rx_s==0 -> frame_err=1, rx_data unchanged, -> BREAK.
//     BREAK : wait for rx_s==1, then -> IDLE.
//             A line held low (break) produces exactly one frame_err.
//   Outputs
//     rx_done and frame_err are registered and never high together.
//     Each lasts exactly 1 cycle.
//     rx_data holds its value until the next good frame.
//   Latency
//     rx_done rises within 1 tick after the mid-stop-bit sample.
//     This is about 9.5 bit times after the start edge.
//     The next start bit is accepted immediately, so back-to-back frames with one
//     stop bit lose no data.
//   Tolerance
//     Sampling at mid-bit tolerates about ±4% total baud mismatch.
// TESTING (bench uses CLK_FREQ=1_600_000, BAUD=100_000 -> DIV=1, plus one run at defaults)
//   1. Reset, then send 0x72 ('r') 8N1.
//      -> exactly one rx_done pulse, rx_data==8'h72, frame_err never 1, rx_busy low after.
//   2. Send 0x6C, 0x75, 0x64, 0x30 back-to-back with no idle gap.
//      -> 4 rx_done pulses in order with matching rx_data, no frame_err.
//   3. Low glitch of 3 ticks on an idle line.
//      -> FSM returns to IDLE, rx_done=0, frame_err=0, rx_data unchanged.
//   4. Send 0x55 with the stop bit forced low, then hold rx low for 20 bit times,
//      then release.
//      -> exactly one frame_err pulse, no rx_done, rx_data keeps its previous value,
//         next 0x31 frame is received correctly.
//   5. Assert rst for 1 cycle during bit 4 of a 0xA5 frame.
//      -> outputs go to reset values, no rx_done for that frame, following 0x32 is
//         received correctly.
//   6. At defaults (DIV=651), send 0x72 with the transmitter 3% fast, then 3% slow.
//      -> rx_data==8'h72 both times.

Source files
------------

// File: rtl/uart_rx_oversample.sv
// 8N1 UART receiver with 16x oversampling, start-bit glitch filter and framing-error flag.
// Emits each good byte with a one-cycle rx_done strobe; a low stop bit raises frame_err instead.
module uart_rx_oversample #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       rx_busy,
  output logic       frame_err
);

  localparam int DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int S_W   = $clog2(OVERSAMPLE);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [S_W-1:0]   S_MID    = S_W'(OVERSAMPLE / 2 - 1);
  localparam logic [S_W-1:0]   S_LAST   = S_W'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  logic             rx_meta_q;
  logic             rx_s_q;
  logic [DIV_W-1:0] div_cnt_q;
  logic             tick;

  state_t           state_q, state_d;
  logic [S_W-1:0]   samp_q, samp_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [7:0]       data_q, data_d;
  logic             done_q, done_d;
  logic             ferr_q, ferr_d;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Free-running so the start edge lands at most one tick off the sample grid.
  assign tick = (div_cnt_q == DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= '0;
    end else if (tick) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      samp_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      samp_q  <= samp_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    samp_d  = samp_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d = S_START;
          samp_d  = '0;
        end
      end

      // A start bit that is high again at mid-bit was a glitch.
      S_START: begin
        if (tick) begin
          if (samp_q == S_MID) begin
            if (!rx_s_q) begin
              state_d = S_DATA;
              samp_d  = '0;
              bit_d   = '0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            samp_d = samp_q + S_W'(1);
          end
        end
      end

      S_DATA: begin
        if (tick) begin
          if (samp_q == S_LAST) begin
            shreg_d = {rx_s_q, shreg_q[7:1]};
            samp_d  = '0;
            if (bit_q == 3'd7) begin
              state_d = S_STOP;
            end else begin
              bit_d = bit_q + 3'd1;
            end
          end else begin
            samp_d = samp_q + S_W'(1);
          end
        end
      end

      // Leaving at mid-stop-bit lets a back-to-back start edge be caught.
      S_STOP: begin
        if (tick) begin
          if (samp_q == S_LAST) begin
            if (rx_s_q) begin
              data_d  = shreg_q;
              done_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = S_BREAK;
            end
          end else begin
            samp_d = samp_q + S_W'(1);
          end
        end
      end

      S_BREAK: begin
        if (rx_s_q) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign rx_data   = data_q;
  assign rx_done   = done_q;
  assign frame_err = ferr_q;
  assign rx_busy   = (state_q != S_IDLE);

endmodule
